ls_queue: RTL and testbench
===========================

LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count, power of 2, range 4..64.
REQ-002 SHALL have parameter ROB_W, default 5, ROB tag width.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rst_c  in  1  synchronous misprediction flush.
REQ-006 SHALL have port rdy  in  1  global enable; when low, all state and outputs hold.
REQ-007 SHALL have ports enq_en_i 1, base_i 32, src2_i 32, imm_i 32, is_store_i 1, funct3_i 3, rob_id_i ROB_W, all inputs from the reservation stage.
REQ-008 SHALL have ports commit_en_i 1 and commit_id_i ROB_W, inputs from the ROB marking a store committed.
REQ-009 SHALL have outputs full_o 1 and empty_o 1.
REQ-010 SHALL have cache outputs mem_en_o 1, mem_rw_o 1 (1=load, 0=store), mem_addr_o 32, mem_data_o 32, mem_width_o 3, and cache inputs mem_rdy_i 1, mem_data_i 32.
REQ-011 SHALL have outputs cdb_en_o 1, cdb_id_o ROB_W, cdb_data_o 32 for load results.
REQ-012 SHALL have outputs st_rdy_o 1 and st_id_o ROB_W, reporting that a store is ready for commit.

Function
REQ-013 SHALL keep entries in a circular FIFO in program order; head and tail wrap modulo DEPTH; count is clog2(DEPTH)+1 bits wide.
REQ-014 SHALL assert full_o when count==DEPTH and empty_o when count==0, both registered and reflecting same-cycle enqueue and dequeue.
REQ-015 SHALL ignore enq_en_i while full_o is high; simultaneous enqueue and dequeue at full SHALL NOT be accepted.
REQ-016 SHALL compute the address as base_i+imm_i modulo 2^32 at enqueue; the width SHALL be 1 for funct3 000/100, 2 for 001/101, 4 for 010, and 0 otherwise.
REQ-017 SHALL pulse st_rdy_o for one cycle, with st_id_o=rob_id_i, in the cycle after a store is enqueued.
REQ-018 SHALL set an entry's committed bit when commit_en_i is high and commit_id_i matches a valid store entry; non-matching commits SHALL be ignored.
REQ-019 SHALL use a state machine with states IDLE, BUSY and DRAIN.
REQ-020 In IDLE, SHALL issue the head entry when it is a load or a committed store: assert mem_en_o next cycle with addr, data and width; state goes to BUSY.
REQ-021 In BUSY, SHALL hold mem_en_o and all request fields stable until mem_rdy_i; on mem_rdy_i SHALL deassert mem_en_o, dequeue the head, and return to IDLE.
REQ-022 Requests SHALL be separated by at least one cycle with mem_en_o low; only one request SHALL be outstanding at a time.
REQ-023 On load completion, SHALL pulse cdb_en_o one cycle later with the head ROB id and extended data: 000 sign byte, 001 sign half, 010 word, 100 zero byte, 101 zero half, else 0.
REQ-024 Store completion SHALL NOT drive the CDB.
REQ-025 On rst_c, SHALL discard all uncommitted entries, setting tail to head plus the committed-store count; committed stores SHALL be retained and still executed.
REQ-026 On rst_c with a load in BUSY, SHALL go to DRAIN: hold the request until mem_rdy_i, discard its data, suppress cdb_en_o, then enter IDLE without dequeuing (the entry is already dropped).
REQ-027 On rst_c with a store in BUSY, the store SHALL complete normally.
REQ-028 rst_c SHALL take priority over enq_en_i and commit_en_i in the same cycle; st_rdy_o and cdb_en_o SHALL be cleared.

Reset
REQ-029 On rst: head=tail=count=0, empty_o=1, full_o=0, mem_en_o=0, cdb_en_o=0, st_rdy_o=0, state=IDLE, all committed bits 0; other data outputs SHALL be 0.
REQ-030 rst SHALL act immediately regardless of clk and rdy.

Verification
REQ-031 Load lw with base=0x100, imm=4, mem_data_i=0x80 -> mem_addr_o=0x104, mem_rw_o=1, width 4; cdb_data_o=0x00000080 one cycle after mem_rdy_i.
REQ-032 lb with mem_data_i=0x000000F0 -> cdb_data_o=0xFFFFFFF0; lbu -> 0x000000F0.
REQ-033 Store sb enqueued with rob_id=3 -> st_rdy_o pulse with id 3, no mem_en_o until commit_en_i with id 3; then mem_rw_o=0, width 1.
REQ-034 Enqueue DEPTH entries -> full_o=1 and the 17th enq ignored (DEPTH=16); drain all -> empty_o=1, head wrapped to 0.
REQ-035 Two committed stores and three loads queued, load in flight, rst_c -> DRAIN, no CDB pulse, count=2, both stores then written.
REQ-036 Hold rdy=0 mid-BUSY for 5 cycles with mem_rdy_i=0 -> all outputs unchanged; rst mid-BUSY -> mem_en_o=0 immediately.

Source files
------------

// File: rtl/ls_queue.sv
// Load/store queue: program-ordered circular FIFO between the reservation stage
// and the data cache. One cache request in flight; load results go to the CDB.
module ls_queue #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_c,
  input  logic             rdy,
  input  logic             enq_en_i,
  input  logic [31:0]      base_i,
  input  logic [31:0]      src2_i,
  input  logic [31:0]      imm_i,
  input  logic             is_store_i,
  input  logic [2:0]       funct3_i,
  input  logic [ROB_W-1:0] rob_id_i,
  input  logic             commit_en_i,
  input  logic [ROB_W-1:0] commit_id_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             mem_en_o,
  output logic             mem_rw_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [2:0]       mem_width_o,
  input  logic             mem_rdy_i,
  input  logic [31:0]      mem_data_i,
  output logic             cdb_en_o,
  output logic [ROB_W-1:0] cdb_id_o,
  output logic [31:0]      cdb_data_o,
  output logic             st_rdy_o,
  output logic [ROB_W-1:0] st_id_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [2:0]       r_f3   [DEPTH];
  logic [2:0]       r_wid  [DEPTH];
  logic [ROB_W-1:0] r_rob  [DEPTH];
  logic [DEPTH-1:0] r_st;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_cmt;

  logic [1:0]    r_state;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic             w_h_st;
  logic             w_enq;
  logic             w_deq;
  logic             w_busy_ld;
  logic             w_issue;
  logic [DEPTH-1:0] w_keep;
  logic [CW-1:0]    w_ccnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [AW-1:0]    w_head_nx;
  logic [AW-1:0]    w_tail_nx;

  function automatic logic [2:0] f3_width(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: f3_width = 3'd1;
      3'b001, 3'b101: f3_width = 3'd2;
      3'b010:         f3_width = 3'd4;
      default:        f3_width = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  ld_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  ld_ext = {{16{d[15]}}, d[15:0]};
      3'b010:  ld_ext = d;
      3'b100:  ld_ext = {24'd0, d[7:0]};
      3'b101:  ld_ext = {16'd0, d[15:0]};
      default: ld_ext = 32'd0;
    endcase
  endfunction

  assign w_h_st    = r_st[r_head];
  assign w_enq     = enq_en_i && !full_o && !rst_c;
  assign w_deq     = (r_state == BUSY) && mem_rdy_i;
  assign w_busy_ld = (r_state == BUSY) && !w_h_st;
  assign w_issue   = (r_state == IDLE) && !rst_c && (r_count != '0) &&
                     (!w_h_st || r_cmt[r_head]);
  // Committed stores survive a flush; in-order commit keeps them contiguous at the front.
  assign w_keep    = r_vld & r_cmt & r_st;

  always_comb begin
    w_ccnt = '0;
    for (int i = 0; i < DEPTH; i++) w_ccnt = w_ccnt + CW'(w_keep[i]);
  end

  // A flushed in-flight load is dropped at flush time by stepping head past it.
  always_comb begin
    w_head_nx = r_head;
    w_tail_nx = r_tail;
    w_cnt_nx  = r_count;
    if (w_deq || (rst_c && w_busy_ld)) w_head_nx = r_head + AW'(1);
    if (rst_c) begin
      w_tail_nx = r_head + AW'(w_busy_ld) + w_ccnt[AW-1:0];
      w_cnt_nx  = w_ccnt - CW'(w_deq && w_h_st);
    end else begin
      if (w_enq) w_tail_nx = r_tail + AW'(1);
      w_cnt_nx = r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cmt <= '0;
      r_st  <= '0;
    end else if (rdy) begin
      if (rst_c) begin
        r_vld <= w_keep;
        r_cmt <= w_keep;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (commit_en_i && r_vld[i] && r_st[i] && (r_rob[i] == commit_id_i))
            r_cmt[i] <= 1'b1;
        if (w_enq) begin
          r_vld[r_tail] <= 1'b1;
          r_cmt[r_tail] <= 1'b0;
          r_st[r_tail]  <= is_store_i;
        end
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_cmt[r_head] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && w_enq) begin
      r_addr[r_tail] <= base_i + imm_i;
      r_data[r_tail] <= src2_i;
      r_f3[r_tail]   <= funct3_i;
      r_wid[r_tail]  <= f3_width(funct3_i);
      r_rob[r_tail]  <= rob_id_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= IDLE;
      full_o      <= 1'b0;
      empty_o     <= 1'b1;
      mem_en_o    <= 1'b0;
      mem_rw_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_width_o <= '0;
      cdb_en_o    <= 1'b0;
      cdb_id_o    <= '0;
      cdb_data_o  <= '0;
      st_rdy_o    <= 1'b0;
      st_id_o     <= '0;
    end else if (rdy) begin
      r_head   <= w_head_nx;
      r_tail   <= w_tail_nx;
      r_count  <= w_cnt_nx;
      full_o   <= (w_cnt_nx == CW'(DEPTH));
      empty_o  <= (w_cnt_nx == '0);
      st_rdy_o <= w_enq && is_store_i;
      if (w_enq && is_store_i) st_id_o <= rob_id_i;
      cdb_en_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            mem_en_o    <= 1'b1;
            mem_rw_o    <= !w_h_st;
            mem_addr_o  <= r_addr[r_head];
            mem_data_o  <= r_data[r_head];
            mem_width_o <= r_wid[r_head];
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_rdy_i) begin
            mem_en_o <= 1'b0;
            r_state  <= IDLE;
            if (!w_h_st && !rst_c) begin
              cdb_en_o   <= 1'b1;
              cdb_id_o   <= r_rob[r_head];
              cdb_data_o <= ld_ext(r_f3[r_head], mem_data_i);
            end
          end else if (rst_c && !w_h_st) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rdy_i) begin
            mem_en_o <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// Scoreboard bench for ls_queue: expected cache requests and CDB results are
// queued at enqueue time and consumed as the DUT issues and completes them.
module tb_ls_queue;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
    logic [31:0] rdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } cdb_t;

  logic        clk, rst, rst_c, rdy;
  logic        enq_en_i, is_store_i;
  logic [31:0] base_i, src2_i, imm_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rob_id_i;
  logic        commit_en_i;
  logic [4:0]  commit_id_i;
  logic        full_o, empty_o;
  logic        mem_en_o, mem_rw_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [2:0]  mem_width_o;
  logic        mem_rdy_i;
  logic [31:0] mem_data_i;
  logic        cdb_en_o;
  logic [4:0]  cdb_id_o;
  logic [31:0] cdb_data_o;
  logic        st_rdy_o;
  logic [4:0]  st_id_o;

  int total = 0;
  int bad   = 0;
  req_t exp_req[$];
  cdb_t exp_cdb[$];

  logic [2:0]  f3s [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [31:0] lds [6] = '{32'h80, 32'hF0, 32'hF0, 32'h8001, 32'h8001, 32'h1234};

  ls_queue #(.DEPTH(16), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .rst_c(rst_c), .rdy(rdy),
    .enq_en_i(enq_en_i), .base_i(base_i), .src2_i(src2_i), .imm_i(imm_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .rob_id_i(rob_id_i),
    .commit_en_i(commit_en_i), .commit_id_i(commit_id_i),
    .full_o(full_o), .empty_o(empty_o),
    .mem_en_o(mem_en_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i),
    .cdb_en_o(cdb_en_o), .cdb_id_o(cdb_id_o), .cdb_data_o(cdb_data_o),
    .st_rdy_o(st_rdy_o), .st_id_o(st_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] m_width(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 3'd1;
    if (f3 == 3'b001 || f3 == 3'b101) return 3'd2;
    if (f3 == 3'b010) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b, h;
    b = {24'd0, d[7:0]};
    h = {16'd0, d[15:0]};
    if (f3 == 3'b000) return d[7]  ? (b | 32'hFFFF_FF00) : b;
    if (f3 == 3'b001) return d[15] ? (h | 32'hFFFF_0000) : h;
    if (f3 == 3'b010) return d;
    if (f3 == 3'b100) return b;
    if (f3 == 3'b101) return h;
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_req.delete();
    exp_cdb.delete();
  endtask

  task automatic enq(input logic st, input logic [2:0] f3, input logic [31:0] base,
                     input logic [31:0] imm, input logic [31:0] src2, input logic [4:0] id,
                     input logic [31:0] rdata, input bit push);
    req_t r;
    cdb_t c;
    enq_en_i = 1'b1; is_store_i = st; funct3_i = f3;
    base_i = base; imm_i = imm; src2_i = src2; rob_id_i = id;
    tick();
    enq_en_i = 1'b0;
    if (push) begin
      r.rw = !st; r.addr = base + imm; r.data = src2; r.width = m_width(f3); r.rdata = rdata;
      exp_req.push_back(r);
      if (!st) begin
        c.id = id; c.data = m_ext(f3, rdata);
        exp_cdb.push_back(c);
      end
    end
  endtask

  task automatic commit(input logic [4:0] id);
    commit_en_i = 1'b1; commit_id_i = id;
    tick();
    commit_en_i = 1'b0;
  endtask

  // Cache model: waits for the next request, checks it, answers after lat cycles.
  task automatic mem_txn(input int lat);
    req_t r;
    cdb_t c;
    int n;
    n = 0;
    while (mem_en_o !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (n >= 40 || exp_req.size() == 0) begin
      bad++;
      $display("FAIL mem_req_wait: mem_en_o=%b queued=%0d, required a pending request", mem_en_o, exp_req.size());
      return;
    end
    r = exp_req.pop_front();
    total++;
    if (mem_rw_o !== r.rw || mem_addr_o !== r.addr || mem_width_o !== r.width ||
        (!r.rw && mem_data_o !== r.data)) begin
      bad++;
      $display("FAIL mem_req: rw=%b addr=%h data=%h w=%0d, required rw=%b addr=%h data=%h w=%0d",
               mem_rw_o, mem_addr_o, mem_data_o, mem_width_o, r.rw, r.addr, r.data, r.width);
    end
    for (int k = 0; k < lat; k++) begin
      tick();
      total++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== r.addr) begin
        bad++;
        $display("FAIL mem_hold: en=%b addr=%h, required en=1 addr=%h", mem_en_o, mem_addr_o, r.addr);
      end
    end
    mem_rdy_i = 1'b1; mem_data_i = r.rdata;
    tick();
    mem_rdy_i = 1'b0; mem_data_i = '0;
    total++;
    if (mem_en_o !== 1'b0) begin
      bad++;
      $display("FAIL mem_gap: mem_en_o=%b after completion, required 0", mem_en_o);
    end
    if (r.rw) begin
      total++;
      if (exp_cdb.size() == 0) begin
        bad++;
        $display("FAIL cdb_queue: no expected CDB entry for completed load");
      end else begin
        c = exp_cdb.pop_front();
        if (cdb_en_o !== 1'b1 || cdb_id_o !== c.id || cdb_data_o !== c.data) begin
          bad++;
          $display("FAIL cdb: en=%b id=%0d data=%h, required en=1 id=%0d data=%h",
                   cdb_en_o, cdb_id_o, cdb_data_o, c.id, c.data);
        end
      end
    end else begin
      total++;
      if (cdb_en_o !== 1'b0) begin
        bad++;
        $display("FAIL st_cdb: cdb_en_o=%b on store completion, required 0", cdb_en_o);
      end
    end
    tick();
    total++;
    if (cdb_en_o !== 1'b0) begin
      bad++;
      $display("FAIL cdb_pulse: cdb_en_o=%b two cycles after completion, required 0", cdb_en_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || mem_en_o !== 1'b0 || cdb_en_o !== 1'b0 ||
        st_rdy_o !== 1'b0 || mem_addr_o !== 32'd0 || cdb_data_o !== 32'd0 || st_id_o !== 5'd0) begin
      bad++;
      $display("FAIL reset: empty=%b full=%b men=%b cdb=%b st=%b addr=%h cdata=%h stid=%0d, required 1 0 0 0 0 0 0 0",
               empty_o, full_o, mem_en_o, cdb_en_o, st_rdy_o, mem_addr_o, cdb_data_o, st_id_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    enq(1'b0, 3'b010, 32'h100, 32'h4, 32'd0, 5'd1, 32'h80, 1'b1);
    total++;
    if (empty_o !== 1'b0) begin
      bad++;
      $display("FAIL not_empty: empty_o=%b, required 0", empty_o);
    end
    mem_txn(2);
    for (int i = 1; i < 6; i++) begin
      enq(1'b0, f3s[i], 32'h200 + 32'(i), 32'h10, 32'd0, 5'(i + 1), lds[i], 1'b1);
      mem_txn(i % 3);
    end
    total++;
    if (empty_o !== 1'b1) begin
      bad++;
      $display("FAIL load_empty: empty_o=%b, required 1", empty_o);
    end
  endtask

  task automatic test_store();
    enq(1'b1, 3'b000, 32'h200, 32'hFFFF_FFFF, 32'h1234_56AB, 5'd3, 32'd0, 1'b1);
    total++;
    if (st_rdy_o !== 1'b1 || st_id_o !== 5'd3) begin
      bad++;
      $display("FAIL st_rdy: st_rdy_o=%b st_id_o=%0d, required 1 and 3", st_rdy_o, st_id_o);
    end
    tick();
    total++;
    if (st_rdy_o !== 1'b0) begin
      bad++;
      $display("FAIL st_pulse: st_rdy_o=%b, required 0", st_rdy_o);
    end
    commit(5'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (mem_en_o !== 1'b0) begin
        bad++;
        $display("FAIL st_wait: mem_en_o=%b before commit, required 0", mem_en_o);
      end
    end
    commit(5'd3);
    mem_txn(1);
  endtask

  task automatic test_back_to_back();
    logic [2:0] fa, fb;
    for (int it = 0; it < 5; it++) begin
      fa = f3s[$urandom_range(0, 5)];
      fb = f3s[$urandom_range(0, 5)];
      enq(1'b0, fa, $urandom, $urandom, 32'd0, 5'($urandom_range(0, 31)), $urandom, 1'b1);
      enq(1'b0, fb, $urandom, $urandom, 32'd0, 5'($urandom_range(0, 31)), $urandom, 1'b1);
      mem_txn($urandom_range(0, 2));
      mem_txn($urandom_range(0, 2));
      enq(1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom, 5'd9, 32'd0, 1'b1);
      commit(5'd9);
      mem_txn($urandom_range(0, 2));
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      enq(1'b1, 3'(i % 3), 32'h1000, 32'(i * 4), 32'(i), 5'(i), 32'd0, 1'b1);
      total++;
      if (st_rdy_o !== 1'b1 || st_id_o !== 5'(i) || full_o !== (i == 15)) begin
        bad++;
        $display("FAIL fill_%0d: st_rdy=%b id=%0d full=%b, required 1 %0d %b",
                 i, st_rdy_o, st_id_o, full_o, i, (i == 15));
      end
    end
    enq(1'b1, 3'b000, 32'h2000, 32'd0, 32'hDEAD, 5'd31, 32'd0, 1'b0);
    total++;
    if (full_o !== 1'b1 || st_rdy_o !== 1'b0) begin
      bad++;
      $display("FAIL full_reject: full=%b st_rdy=%b, required 1 and 0", full_o, st_rdy_o);
    end
    for (int i = 0; i < 16; i++) commit(5'(i));
    for (int i = 0; i < 16; i++) mem_txn(0);
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      bad++;
      $display("FAIL drained: empty=%b full=%b, required 1 and 0", empty_o, full_o);
    end
    enq(1'b0, 3'b001, 32'h3000, 32'h2, 32'd0, 5'd17, 32'h0000_7FFE, 1'b1);
    mem_txn(1);
  endtask

  task automatic test_flush();
    do_reset();
    enq(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd10, 32'd0, 1'b0);
    enq(1'b1, 3'b010, 32'h400, 32'h8, 32'hCAFE_0001, 5'd11, 32'd0, 1'b1);
    enq(1'b1, 3'b001, 32'h400, 32'hC, 32'hCAFE_0002, 5'd12, 32'd0, 1'b1);
    enq(1'b0, 3'b010, 32'h500, 32'd0, 32'd0, 5'd13, 32'd0, 1'b0);
    enq(1'b0, 3'b000, 32'h504, 32'd0, 32'd0, 5'd14, 32'd0, 1'b0);
    total++;
    if (mem_en_o !== 1'b1 || mem_rw_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      bad++;
      $display("FAIL flush_ld_issue: en=%b rw=%b addr=%h, required 1 1 00000300", mem_en_o, mem_rw_o, mem_addr_o);
    end
    commit(5'd11);
    commit(5'd12);
    rst_c = 1'b1;
    enq_en_i = 1'b1; is_store_i = 1'b1; rob_id_i = 5'd20; funct3_i = 3'b010;
    tick();
    rst_c = 1'b0; enq_en_i = 1'b0;
    total++;
    if (st_rdy_o !== 1'b0 || cdb_en_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_clr: st_rdy=%b cdb=%b, required 0 0", st_rdy_o, cdb_en_o);
    end
    tick();
    tick();
    total++;
    if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h300 || empty_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_hold: en=%b addr=%h empty=%b, required 1 00000300 0", mem_en_o, mem_addr_o, empty_o);
    end
    mem_rdy_i = 1'b1; mem_data_i = 32'h55;
    tick();
    mem_rdy_i = 1'b0; mem_data_i = '0;
    total++;
    if (mem_en_o !== 1'b0 || cdb_en_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_done: en=%b cdb=%b, required 0 0", mem_en_o, cdb_en_o);
    end
    tick();
    total++;
    if (cdb_en_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_cdb: cdb_en_o=%b, required 0", cdb_en_o);
    end
    mem_txn(1);
    mem_txn(0);
    total++;
    if (empty_o !== 1'b1 || exp_req.size() != 0) begin
      bad++;
      $display("FAIL flush_count: empty=%b left=%0d, required 1 0", empty_o, exp_req.size());
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (mem_en_o !== 1'b0) begin
        bad++;
        $display("FAIL flush_dropped: mem_en_o=%b addr=%h, required 0", mem_en_o, mem_addr_o);
      end
    end
  endtask

  task automatic test_rdy_hold();
    int n;
    n = 0;
    do_reset();
    enq(1'b0, 3'b010, 32'h40, 32'd0, 32'd0, 5'd5, 32'd0, 1'b0);
    while (mem_en_o !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (mem_en_o !== 1'b1) begin
      bad++;
      $display("FAIL hold_issue: mem_en_o=%b, required 1", mem_en_o);
    end
    rdy = 1'b0;
    enq_en_i = 1'b1; is_store_i = 1'b1; rob_id_i = 5'd7; base_i = 32'h80; mem_rdy_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_rw_o !== 1'b1 || mem_width_o !== 3'd4 ||
          st_rdy_o !== 1'b0 || empty_o !== 1'b0 || cdb_en_o !== 1'b0) begin
        bad++;
        $display("FAIL rdy_hold: en=%b addr=%h rw=%b w=%0d st=%b empty=%b cdb=%b, required 1 00000040 1 4 0 0 0",
                 mem_en_o, mem_addr_o, mem_rw_o, mem_width_o, st_rdy_o, empty_o, cdb_en_o);
      end
    end
    enq_en_i = 1'b0; is_store_i = 1'b0;
    rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_en_o !== 1'b0 || empty_o !== 1'b1 || mem_addr_o !== 32'd0) begin
      bad++;
      $display("FAIL rst_async: en=%b empty=%b addr=%h, required 0 1 00000000", mem_en_o, empty_o, mem_addr_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; rst_c = 1'b0; rdy = 1'b1;
    enq_en_i = 1'b0; is_store_i = 1'b0; base_i = '0; src2_i = '0; imm_i = '0;
    funct3_i = '0; rob_id_i = '0; commit_en_i = 1'b0; commit_id_i = '0;
    mem_rdy_i = 1'b0; mem_data_i = '0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_full();
    test_flush();
    test_rdy_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
